// File: rtl/ctrl_respawn_ranas_pkg.sv
// Shared types and default constants for the per-frog respawn controller.
package pkg_ranas;

  typedef enum logic [2:0] {
    INICIO  = 3'd0,
    ESPERA  = 3'd1,
    META    = 3'd2,
    MUERTA  = 3'd3,
    AGOTADA = 3'd4
  } estado_rana_t;

  localparam logic [2:0] ESTADO_JUEGO_DEF = 3'b111;
  localparam logic [2:0] POS_META_DEF     = 3'b111;

endpackage

// File: rtl/ctrl_rana_canal.sv
// One frog channel: start/respawn FSM, lives register and respawn delay counter.
module ctrl_rana_canal
  import pkg_ranas::*;
#(
  parameter int unsigned               DATAWIDTH_POS = 3,
  parameter logic [DATAWIDTH_POS-1:0]  POS_META      = DATAWIDTH_POS'(POS_META_DEF),
  parameter int unsigned               VIDAS_INI     = 3,
  parameter int unsigned               VIDAS_W       = 2,
  parameter int unsigned               RETARDO       = 25000000,
  parameter int unsigned               RETARDO_W     = 25
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     abort_i,
  input  logic [DATAWIDTH_POS-1:0] posy_i,
  input  logic                     choque_i,
  output logic                     rana_ini_o,
  output logic                     viva_o,
  output logic [VIDAS_W-1:0]       vidas_o,
  output logic                     meta_o,
  output logic                     agotada_c_o
);

  localparam logic [VIDAS_W-1:0]   VIDAS_CARGA = VIDAS_W'(VIDAS_INI);
  localparam logic [RETARDO_W-1:0] CNT_CARGA   = RETARDO_W'(RETARDO - 1);

  estado_rana_t         estado_q, estado_d;
  logic [VIDAS_W-1:0]   vidas_q, vidas_d;
  logic [RETARDO_W-1:0] cnt_q, cnt_d;
  logic                 rana_ini_q, rana_ini_d;
  logic                 viva_q, viva_d;
  logic                 meta_q, meta_d;

  // Next state; outputs are registered from the next state so they track it exactly.
  always_comb begin
    estado_d = estado_q;
    vidas_d  = vidas_q;
    cnt_d    = cnt_q;
    unique case (estado_q)
      INICIO: if (!abort_i) estado_d = ESPERA;
      ESPERA: begin
        if (abort_i) begin
          estado_d = INICIO;
        end else if (posy_i == POS_META) begin
          estado_d = META;
        end else if (choque_i) begin
          if (vidas_q <= VIDAS_W'(1)) begin
            estado_d = AGOTADA;
            vidas_d  = '0;
          end else begin
            estado_d = MUERTA;
            vidas_d  = vidas_q - VIDAS_W'(1);
            cnt_d    = CNT_CARGA;
          end
        end
      end
      META: estado_d = abort_i ? INICIO : ESPERA;
      MUERTA: begin
        if (abort_i) begin
          estado_d = INICIO;
        end else if (cnt_q == '0) begin
          estado_d = ESPERA;
        end else begin
          cnt_d = cnt_q - RETARDO_W'(1);
        end
      end
      AGOTADA: if (abort_i) estado_d = INICIO;
      default: estado_d = INICIO;
    endcase
    if (estado_d == INICIO) vidas_d = VIDAS_CARGA;
    rana_ini_d = (estado_d != ESPERA);
    viva_d     = (estado_d != AGOTADA);
    meta_d     = (estado_d == META);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      estado_q   <= INICIO;
      vidas_q    <= VIDAS_CARGA;
      cnt_q      <= '0;
      rana_ini_q <= 1'b1;
      viva_q     <= 1'b1;
      meta_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      vidas_q    <= vidas_d;
      cnt_q      <= cnt_d;
      rana_ini_q <= rana_ini_d;
      viva_q     <= viva_d;
      meta_q     <= meta_d;
    end
  end

  assign rana_ini_o  = rana_ini_q;
  assign viva_o      = viva_q;
  assign vidas_o     = vidas_q;
  assign meta_o      = meta_q;
  assign agotada_c_o = (estado_d == AGOTADA);

endmodule

// File: rtl/ctrl_respawn_ranas.sv
// N-frog start-position / respawn controller with lives, goal pulse and game-over flag.
module ctrl_respawn_ranas
  import pkg_ranas::*;
#(
  parameter int unsigned                  N_RANAS          = 2,
  parameter int unsigned                  DATAWIDTH_POS    = 3,
  parameter int unsigned                  DATAWIDTH_ESTADO = 3,
  parameter logic [DATAWIDTH_ESTADO-1:0]  ESTADO_JUEGO     = DATAWIDTH_ESTADO'(ESTADO_JUEGO_DEF),
  parameter logic [DATAWIDTH_POS-1:0]     POS_META         = DATAWIDTH_POS'(POS_META_DEF),
  parameter int unsigned                  VIDAS_INI        = 3,
  parameter int unsigned                  VIDAS_W          = 2,
  parameter int unsigned                  RETARDO          = 25000000,
  parameter int unsigned                  RETARDO_W        = 25
) (
  input  logic                               CIR_CLOCK_50,
  input  logic                               CIR_RESET,
  input  logic [DATAWIDTH_ESTADO-1:0]        CIR_ESTADO_IN,
  input  logic [N_RANAS*DATAWIDTH_POS-1:0]   CIR_POSY_IN,
  input  logic [N_RANAS-1:0]                 CIR_CHOQUE_IN,
  input  logic                               CIR_PERDIO_IN,
  input  logic                               CIR_GANO_IN,
  output logic [N_RANAS-1:0]                 CIR_RANA_INI_OUT,
  output logic [N_RANAS-1:0]                 CIR_RANA_VIVA_OUT,
  output logic [N_RANAS*VIDAS_W-1:0]         CIR_VIDAS_OUT,
  output logic [N_RANAS-1:0]                 CIR_META_OUT,
  output logic                               CIR_FIN_OUT
);

  logic               abort_c;
  logic [N_RANAS-1:0] agotada_c;
  logic               fin_q;

  assign abort_c = CIR_PERDIO_IN | CIR_GANO_IN | (CIR_ESTADO_IN != ESTADO_JUEGO);

  for (genvar i = 0; i < N_RANAS; i++) begin : g_canal
    ctrl_rana_canal #(
      .DATAWIDTH_POS (DATAWIDTH_POS),
      .POS_META      (POS_META),
      .VIDAS_INI     (VIDAS_INI),
      .VIDAS_W       (VIDAS_W),
      .RETARDO       (RETARDO),
      .RETARDO_W     (RETARDO_W)
    ) u_canal (
      .clk_i       (CIR_CLOCK_50),
      .rst_i       (CIR_RESET),
      .abort_i     (abort_c),
      .posy_i      (CIR_POSY_IN[i*DATAWIDTH_POS +: DATAWIDTH_POS]),
      .choque_i    (CIR_CHOQUE_IN[i]),
      .rana_ini_o  (CIR_RANA_INI_OUT[i]),
      .viva_o      (CIR_RANA_VIVA_OUT[i]),
      .vidas_o     (CIR_VIDAS_OUT[i*VIDAS_W +: VIDAS_W]),
      .meta_o      (CIR_META_OUT[i]),
      .agotada_c_o (agotada_c[i])
    );
  end

  // Game over registered from the channels' next-state flags, so it tracks their AGOTADA states.
  always_ff @(posedge CIR_CLOCK_50 or posedge CIR_RESET) begin
    if (CIR_RESET) fin_q <= 1'b0;
    else           fin_q <= &agotada_c;
  end

  assign CIR_FIN_OUT = fin_q;

endmodule
